// File: rtl/ann_pkg.sv
// ann_pkg: shared defaults, loader state type and vector type for the ANN datapath.
package ann_pkg;

   localparam int ANN_WORD_SIZE  = 16;
   localparam int ANN_ADDR_WIDTH = 10;
   localparam int ANN_N_INPUTS   = 4;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_X,
      LOAD_W,
      DRAIN,
      DONE
   } loader_state_t;

   typedef logic [ANN_N_INPUTS*ANN_WORD_SIZE-1:0] word_vec_t;

   // True when a span of 'count' words starting at 'base' runs past the top of
   // an address space that is 'addrWidth' bits wide.
   function automatic logic spanOverflows(input logic [31:0] base,
                                          input logic [31:0] count,
                                          input int          addrWidth);
      logic [32:0] lastAddr;
      lastAddr = {1'b0, base} + {1'b0, count} - 33'd1;
      return lastAddr > ((33'd1 << addrWidth) - 33'd1);
   endfunction

endpackage

// File: rtl/vec_assembler.sv
// vec_assembler: builds one vector from single words written by index.
// The full flag rises once the last word has been written; clear empties it.
module vec_assembler #(
   parameter int WORD_SIZE = 16,
   parameter int N_WORDS   = 4,
   parameter int IDX_W     = 2
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic                         i_clear,
   input  logic                         i_we,
   input  logic [IDX_W-1:0]             i_idx,
   input  logic [WORD_SIZE-1:0]         i_data,
   output logic [N_WORDS*WORD_SIZE-1:0] o_vec,
   output logic                         o_full
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

   logic [N_WORDS*WORD_SIZE-1:0] r_vec;
   logic                         r_full;

   // Capture each returning word into its slot; writing the last slot marks the vector complete.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_clear) begin
         r_vec  <= '0;
         r_full <= 1'b0;
      end else if (i_we) begin
         r_vec[int'(i_idx)*WORD_SIZE +: WORD_SIZE] <= i_data;
         if (i_idx == LAST_IDX) begin
            r_full <= 1'b1;
         end
      end
   end

   assign o_vec  = r_vec;
   assign o_full = r_full;

endmodule

// File: rtl/layer_loader.sv
// layer_loader: fetches the activation vector, then one weight vector per neuron,
// from single-word RAM reads and hands them to the layer over valid/ready.
// Optional feature macro: LAYER_LOADER_ADDR_CHECK_EN (reject runs whose address
// span would wrap past the top of RAM and raise err_o instead of reading).
module layer_loader
   import ann_pkg::*;
#(
   parameter int WORD_SIZE  = ANN_WORD_SIZE,
   parameter int ADDR_WIDTH = ANN_ADDR_WIDTH,
   parameter int N_INPUTS   = 4,
   parameter int N_NEURONS  = 8
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          start_i,
   input  logic [ADDR_WIDTH-1:0]         x_base_i,
   input  logic [ADDR_WIDTH-1:0]         w_base_i,
   output logic                          ram_re_o,
   output logic [ADDR_WIDTH-1:0]         ram_addr_o,
   input  logic [WORD_SIZE-1:0]          ram_rdata_i,
   output logic                          valid_o,
   input  logic                          ready_i,
   output logic [N_INPUTS*WORD_SIZE-1:0] x_o,
   output logic [N_INPUTS*WORD_SIZE-1:0] weights_o,
   output logic                          busy_o,
   output logic                          done_o,
   output logic                          err_o
);

   localparam int IDX_W = (N_INPUTS  > 1) ? $clog2(N_INPUTS)  : 1;
   localparam int NEU_W = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INPUTS - 1);
   localparam logic [NEU_W-1:0] LAST_NEU = NEU_W'(N_NEURONS - 1);

   loader_state_t r_state, w_nextState;

   logic [ADDR_WIDTH-1:0]         r_xBase, r_wPtr, r_addr, w_issueAddr;
   logic [IDX_W-1:0]              r_idx, r_reIdx, r_rdIdx;
   logic [NEU_W-1:0]              r_neuron;
   logic                          r_wBusy, r_ovf, r_re, r_reIsW, r_rdValid, r_rdIsW, r_valid;
   logic [N_INPUTS*WORD_SIZE-1:0] r_weights, w_xVec, w_wVec;
   logic                          w_issue, w_issueIsW, w_start, w_startOvf, w_copy;
   logic                          w_xFull, w_wFull, w_xWe, w_wWe;

`ifdef LAYER_LOADER_ADDR_CHECK_EN
   logic r_err;

   assign w_startOvf = spanOverflows(32'(x_base_i), 32'(N_INPUTS), ADDR_WIDTH) ||
                       spanOverflows(32'(w_base_i), 32'(N_NEURONS*N_INPUTS), ADDR_WIDTH);

   // Error flag rises as the rejected run reaches DONE and holds until the next accepted start.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_err <= 1'b0;
      end else if (w_start) begin
         r_err <= 1'b0;
      end else if (r_state == LOAD_X && r_ovf) begin
         r_err <= 1'b1;
      end
   end

   assign err_o = r_err;
`else
   assign w_startOvf = 1'b0;
   assign err_o      = 1'b0;
`endif

   // The assembled weight vector moves to the output stage when that stage is free or handing off now.
   assign w_copy = w_wFull && w_xFull && (!r_valid || ready_i);
   assign w_xWe  = r_rdValid && !r_rdIsW;
   assign w_wWe  = r_rdValid &&  r_rdIsW;

   // State register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next state and read-issue decision; a new neuron starts only once the assembler is free.
   always_comb begin
      w_nextState = r_state;
      w_issue     = 1'b0;
      w_issueIsW  = 1'b0;
      w_issueAddr = r_wPtr;
      w_start     = 1'b0;
      busy_o      = (r_state != IDLE);
      done_o      = (r_state == DONE);
      case (r_state)
         IDLE: begin
            if (start_i) begin
               w_start     = 1'b1;
               w_issue     = !w_startOvf;
               w_issueAddr = x_base_i;
               w_nextState = (w_startOvf || LAST_IDX != '0) ? LOAD_X : LOAD_W;
            end
         end
         LOAD_X: begin
            if (r_ovf) begin
               w_nextState = DONE;
            end else begin
               w_issue     = 1'b1;
               w_issueAddr = r_xBase + ADDR_WIDTH'(r_idx);
               if (r_idx == LAST_IDX) begin
                  w_nextState = LOAD_W;
               end
            end
         end
         LOAD_W: begin
            if (r_idx != '0 || !r_wBusy || w_copy) begin
               w_issue    = 1'b1;
               w_issueIsW = 1'b1;
               if (r_idx == LAST_IDX && r_neuron == LAST_NEU) begin
                  w_nextState = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (!r_wBusy && r_valid && ready_i) begin
               w_nextState = DONE;
            end
         end
         DONE: begin
            w_nextState = IDLE;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Run bookkeeping: latched bases, word index, neuron count and assembler occupancy.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_xBase  <= '0;
         r_wPtr   <= '0;
         r_idx    <= '0;
         r_neuron <= '0;
         r_wBusy  <= 1'b0;
         r_ovf    <= 1'b0;
      end else begin
         if (w_start) begin
            r_xBase  <= x_base_i;
            r_wPtr   <= w_base_i;
            r_neuron <= '0;
            r_ovf    <= w_startOvf;
         end
         if (w_issue) begin
            r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
            if (w_issueIsW) begin
               r_wPtr <= r_wPtr + ADDR_WIDTH'(1);
               if (r_idx == LAST_IDX) begin
                  r_neuron <= r_neuron + NEU_W'(1);
               end
            end
         end
         if (w_start) begin
            r_wBusy <= 1'b0;
         end else if (w_issue && w_issueIsW && r_idx == '0) begin
            r_wBusy <= 1'b1;
         end else if (w_copy) begin
            r_wBusy <= 1'b0;
         end
      end
   end

   // Registered read port plus a one-cycle tag pipe that matches each return to its slot.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_re      <= 1'b0;
         r_addr    <= '0;
         r_reIdx   <= '0;
         r_reIsW   <= 1'b0;
         r_rdValid <= 1'b0;
         r_rdIdx   <= '0;
         r_rdIsW   <= 1'b0;
      end else begin
         r_re <= w_issue;
         if (w_issue) begin
            r_addr  <= w_issueAddr;
            r_reIdx <= r_idx;
            r_reIsW <= w_issueIsW;
         end
         r_rdValid <= r_re;
         r_rdIdx   <= r_reIdx;
         r_rdIsW   <= r_reIsW;
      end
   end

   // Output stage: holds a weight vector until the layer takes it; refill on the same edge is allowed.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_valid   <= 1'b0;
         r_weights <= '0;
      end else if (w_copy) begin
         r_valid   <= 1'b1;
         r_weights <= w_wVec;
      end else if (ready_i) begin
         r_valid <= 1'b0;
      end
   end

   vec_assembler #(
      .WORD_SIZE (WORD_SIZE),
      .N_WORDS   (N_INPUTS),
      .IDX_W     (IDX_W)
   ) u_xAsm (
      .i_clk   (clk_i),
      .i_rst   (rst_i),
      .i_clear (w_start),
      .i_we    (w_xWe),
      .i_idx   (r_rdIdx),
      .i_data  (ram_rdata_i),
      .o_vec   (w_xVec),
      .o_full  (w_xFull)
   );

   vec_assembler #(
      .WORD_SIZE (WORD_SIZE),
      .N_WORDS   (N_INPUTS),
      .IDX_W     (IDX_W)
   ) u_wAsm (
      .i_clk   (clk_i),
      .i_rst   (rst_i),
      .i_clear (w_start || w_copy),
      .i_we    (w_wWe),
      .i_idx   (r_rdIdx),
      .i_data  (ram_rdata_i),
      .o_vec   (w_wVec),
      .o_full  (w_wFull)
   );

   assign ram_re_o   = r_re;
   assign ram_addr_o = r_addr;
   assign valid_o    = r_valid;
   assign x_o        = w_xVec;
   assign weights_o  = r_weights;

endmodule

// File: tb/tb_layer_loader.sv
// tb_layer_loader: drives layer_loader against a RAM that returns data = address
// and compares every read address and transferred vector with an expected list.
module tb_layer_loader;
   import ann_pkg::*;

   localparam int WS = 16;
   localparam int AW = 10;
   localparam int NI = 4;
   localparam int NN = 3;

   logic          clk = 1'b0;
   logic          rst, start, ready, ramRe, outValid, busy, done, err;
   logic [AW-1:0] xBase, wBase, ramAddr;
   logic [WS-1:0] ramRdata;
   word_vec_t     xVec, weights;

   int errors;
   int checks;

   always #5 clk = ~clk;

   layer_loader #(
      .WORD_SIZE  (WS),
      .ADDR_WIDTH (AW),
      .N_INPUTS   (NI),
      .N_NEURONS  (NN)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .start_i     (start),
      .x_base_i    (xBase),
      .w_base_i    (wBase),
      .ram_re_o    (ramRe),
      .ram_addr_o  (ramAddr),
      .ram_rdata_i (ramRdata),
      .valid_o     (outValid),
      .ready_i     (ready),
      .x_o         (xVec),
      .weights_o   (weights),
      .busy_o      (busy),
      .done_o      (done),
      .err_o       (err)
   );

   // RAM model: one-cycle read latency, data equals address; garbage when not reading.
   always @(posedge clk) begin
      ramRdata <= ramRe ? WS'(ramAddr) : WS'($urandom);
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected vector of NI consecutive words starting at base, wrapped to the address space.
   function automatic word_vec_t vecAt(input int base);
      word_vec_t v;
      v = '0;
      for (int j = 0; j < NI; j++) begin
         v[j*WS +: WS] = WS'((base + j) & 'h3FF);
      end
      return v;
   endfunction

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, ":re"},      64'(ramRe),    0);
      checkOutput({tag, ":addr"},    64'(ramAddr),  0);
      checkOutput({tag, ":valid"},   64'(outValid), 0);
      checkOutput({tag, ":x"},       xVec,          0);
      checkOutput({tag, ":weights"}, weights,       0);
      checkOutput({tag, ":busy"},    64'(busy),     0);
      checkOutput({tag, ":done"},    64'(done),     0);
      checkOutput({tag, ":err"},     64'(err),      0);
   endtask

   // One complete run: start, then cycle-by-cycle checks until done (or abort by reset).
   task automatic applyStimulus(input string tag, input int xb, input int wb, input int stallLen,
                                input int restartCyc, input bit randReady, input int abortCyc);
      word_vec_t expVec[$];
      int        expAddr[$];
      int        cyc, firstValid, lastHs, hsCount, readCount;
      bit        doneSeen;
      expVec  = {};
      expAddr = {};
      for (int j = 0; j < NI; j++) expAddr.push_back((xb + j) & 'h3FF);
      for (int n = 0; n < NN; n++) begin
         expVec.push_back(vecAt(wb + n*NI));
         for (int j = 0; j < NI; j++) expAddr.push_back((wb + n*NI + j) & 'h3FF);
      end
      xBase = AW'(xb);
      wBase = AW'(wb);
      start = 1'b1;
      ready = 1'b1;
      @(posedge clk); #1;
      start      = 1'b0;
      firstValid = -1;
      lastHs     = -100;
      hsCount    = 0;
      readCount  = 0;
      doneSeen   = 1'b0;
      cyc        = 1;
      checkOutput({tag, ":err_cleared"}, 64'(err), 0);
      while (cyc < 300 && !doneSeen) begin
         if (cyc == abortCyc) begin
            rst = 1'b1;
            @(posedge clk); #1;
            checkResetOutputs({tag, ":reset"});
            rst = 1'b0;
            return;
         end
         xBase = AW'($urandom);
         wBase = AW'($urandom);
         start = (cyc == restartCyc);
         checkOutput({tag, ":busy"}, 64'(busy), 1);
         if (ramRe) begin
            readCount++;
            if (expAddr.size() == 0) checkOutput({tag, ":extra_read"}, 1, 0);
            else checkOutput({tag, ":read_addr"}, 64'(ramAddr), 64'(expAddr.pop_front()));
         end
         if (cyc <= 10) checkOutput({tag, ":re_window"}, 64'(ramRe), 64'(cyc <= 2*NI));
         if (stallLen > 0 && firstValid >= 0 && cyc == firstValid + stallLen - 1)
            checkOutput({tag, ":reads_during_stall"}, 64'(readCount), 64'(3*NI));
         if (outValid) begin
            if (firstValid < 0) begin
               firstValid = cyc;
               checkOutput({tag, ":first_valid_cycle"}, 64'(cyc), 64'(2*NI + 3));
               checkOutput({tag, ":x_vector"}, xVec, vecAt(xb));
            end
            if (expVec.size() == 0) checkOutput({tag, ":extra_vector"}, 1, 0);
            else checkOutput({tag, ":weights"}, weights, expVec[0]);
         end
         if (stallLen > 0 && firstValid >= 0 && cyc < firstValid + stallLen) ready = 1'b0;
         else if (randReady) ready = 1'($urandom_range(0, 1));
         else ready = 1'b1;
         if (outValid && ready && expVec.size() > 0) begin
            void'(expVec.pop_front());
            if (stallLen == 0 && !randReady && lastHs > 0)
               checkOutput({tag, ":vector_period"}, 64'(cyc - lastHs), 64'(NI + 2));
            hsCount++;
            lastHs = cyc;
         end
         if (done) begin
            doneSeen = 1'b1;
            checkOutput({tag, ":done_cycle"}, 64'(cyc), 64'(lastHs + 1));
            checkOutput({tag, ":err_at_done"}, 64'(err), 0);
            checkOutput({tag, ":x_stable"}, xVec, vecAt(xb));
         end
         @(posedge clk); #1;
         cyc++;
      end
      start = 1'b0;
      if (!doneSeen) checkOutput({tag, ":timeout"}, 0, 1);
      checkOutput({tag, ":vectors_transferred"}, 64'(hsCount), 64'(NN));
      checkOutput({tag, ":reads_issued"}, 64'(readCount), 64'(NI + NI*NN));
      checkOutput({tag, ":done_pulse_end"}, 64'(done), 0);
      checkOutput({tag, ":busy_after_done"}, 64'(busy), 0);
      checkOutput({tag, ":valid_after_done"}, 64'(outValid), 0);
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst    = 1'b1;
      start  = 1'b0;
      ready  = 1'b0;
      xBase  = '0;
      wBase  = '0;
      repeat (2) @(posedge clk);
      #1;
      checkResetOutputs("por");
      rst = 1'b0;
      @(posedge clk); #1;

      $display("[TB] basic run");
      applyStimulus("basic", 'h010, 'h100, 0, -1, 1'b0, -1);
      $display("[TB] backpressure run");
      applyStimulus("stall", 'h010, 'h100, 20, -1, 1'b0, -1);
      $display("[TB] start pulsed mid-run");
      applyStimulus("restart", 'h010, 'h100, 0, 5, 1'b0, -1);
      $display("[TB] reset during LOAD_W");
      applyStimulus("reset_mid", 'h010, 'h100, 0, -1, 1'b0, 7);
      applyStimulus("after_reset", 'h010, 'h100, 0, -1, 1'b0, -1);

`ifdef LAYER_LOADER_ADDR_CHECK_EN
      $display("[TB] overflowing weight span rejected");
      xBase = 10'h010;
      wBase = 10'h3F8;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      checkOutput("ovf:c1_re",   64'(ramRe), 0);
      checkOutput("ovf:c1_done", 64'(done),  0);
      @(posedge clk); #1;
      checkOutput("ovf:c2_re",   64'(ramRe), 0);
      checkOutput("ovf:c2_done", 64'(done),  1);
      checkOutput("ovf:c2_err",  64'(err),   1);
      @(posedge clk); #1;
      checkOutput("ovf:c3_re",   64'(ramRe), 0);
      checkOutput("ovf:c3_done", 64'(done),  0);
      checkOutput("ovf:c3_busy", 64'(busy),  0);
      checkOutput("ovf:c3_err",  64'(err),   1);
`else
      $display("[TB] weight span wraps");
      applyStimulus("wrap", 'h010, 'h3F8, 0, -1, 1'b0, -1);
`endif

      $display("[TB] random bases and ready");
      for (int k = 0; k < 4; k++) begin
         applyStimulus("random", int'($urandom_range(0, 1020)), int'($urandom_range(0, 1012)),
                       0, -1, 1'b1, -1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
